// File: rtl/aes_decrypt_fsm_if.sv
// Bus bundle between the AES-128 decryption control FSM and its host/datapath.
// master: host/datapath side (drives bus data and ack pulses).
// slave:  controller side (drives requests, round index and captured registers).
interface aes_decrypt_fsm_if;
  logic         start;
  logic [127:0] data;
  logic         i_data_received_text;
  logic         i_data_received_key;
  logic         i_inv_shift_rows;
  logic         i_inv_byte_subs;
  logic         i_key_addition;
  logic         i_inv_mix_columns;
  logic         i_round_key_get_ready;
  logic         i_done;

  logic         o_load;
  logic         o_calc_round_key;
  logic         o_calc_inv_round_key;
  logic         o_add;
  logic         o_inv_shift_rows;
  logic         o_inv_substitute;
  logic         o_inv_mix_columns;
  logic         o_send;
  logic         o_error;
  logic [3:0]   round_cnt;
  logic [127:0] cipher_text;
  logic [127:0] prime_key;
  logic [127:0] plain_text;

  modport master (
    output start, data, i_data_received_text, i_data_received_key, i_inv_shift_rows,
           i_inv_byte_subs, i_key_addition, i_inv_mix_columns, i_round_key_get_ready, i_done,
    input  o_load, o_calc_round_key, o_calc_inv_round_key, o_add, o_inv_shift_rows,
           o_inv_substitute, o_inv_mix_columns, o_send, o_error, round_cnt,
           cipher_text, prime_key, plain_text
  );

  modport slave (
    input  start, data, i_data_received_text, i_data_received_key, i_inv_shift_rows,
           i_inv_byte_subs, i_key_addition, i_inv_mix_columns, i_round_key_get_ready, i_done,
    output o_load, o_calc_round_key, o_calc_inv_round_key, o_add, o_inv_shift_rows,
           o_inv_substitute, o_inv_mix_columns, o_send, o_error, round_cnt,
           cipher_text, prime_key, plain_text
  );
endinterface

// File: rtl/aes_decrypt_fsm.sv
// AES-128 decryption control FSM.
// Loads ciphertext and key from the shared bus, runs the forward key expansion,
// then the inverse rounds, and holds the captured plaintext until the host takes it.
// Optional ack-wait timeout: define AES_DEC_TIMEOUT_EN (adds TIMEOUT_CYCLES parameter).
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start
// S_LOAD_TXT  | o_load, waiting for ciphertext on the bus
// S_LOAD_KEY  | o_load, waiting for key on the bus
// S_KEXP      | o_calc_round_key, one round_cnt increment per ack up to NR
// S_INIT_ADD  | o_add, initial AddRoundKey with the last round key
// S_INV_KEY   | o_calc_inv_round_key, round_cnt decrements on ack
// S_INV_SHIFT | o_inv_shift_rows
// S_INV_SUB   | o_inv_substitute
// S_ADD       | o_add, last one (round_cnt==0) captures plain_text
// S_INV_MIX   | o_inv_mix_columns
// S_SEND      | o_send, plain_text valid until i_done
module aes_decrypt_fsm #(
  parameter int NR = 10
`ifdef AES_DEC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  aes_decrypt_fsm_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_TXT, S_LOAD_KEY, S_KEXP, S_INIT_ADD, S_INV_KEY,
    S_INV_SHIFT, S_INV_SUB, S_ADD, S_INV_MIX, S_SEND
  } state_t;

  localparam logic [3:0] LAST_FWD = 4'(NR - 1);

  // request vector bit positions
  localparam int R_LOAD  = 7;
  localparam int R_KEXP  = 6;
  localparam int R_IKEY  = 5;
  localparam int R_ADD   = 4;
  localparam int R_SHIFT = 3;
  localparam int R_SUB   = 2;
  localparam int R_MIX   = 1;
  localparam int R_SEND  = 0;

  state_t       state_q, state_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic [127:0] cipher_q, cipher_d;
  logic [127:0] key_q, key_d;
  logic [127:0] plain_q, plain_d;
  logic [7:0]   req_q, req_d;

`ifdef AES_DEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_q, wait_d;
  logic          error_q;
  logic          in_req;
  logic          timeout;

  assign in_req  = (state_q != S_IDLE) && (state_q != S_SEND);
  assign timeout = in_req && (wait_q == TW'(TIMEOUT_CYCLES));
`endif

  // next-state and data capture; only the ack matching the current state is honoured
  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    cipher_d    = cipher_q;
    key_d       = key_q;
    plain_d     = plain_q;
    case (state_q)
      S_IDLE:      if (bus.start) state_d = S_LOAD_TXT;
      S_LOAD_TXT:  if (bus.i_data_received_text) begin
                     cipher_d = bus.data;
                     state_d  = S_LOAD_KEY;
                   end
      S_LOAD_KEY:  if (bus.i_data_received_key) begin
                     key_d       = bus.data;
                     round_cnt_d = 4'd0;
                     state_d     = S_KEXP;
                   end
      S_KEXP:      if (bus.i_round_key_get_ready) begin
                     round_cnt_d = round_cnt_q + 4'd1;
                     if (round_cnt_q == LAST_FWD) state_d = S_INIT_ADD;
                   end
      S_INIT_ADD:  if (bus.i_key_addition) state_d = S_INV_KEY;
      S_INV_KEY:   if (bus.i_round_key_get_ready) begin
                     round_cnt_d = round_cnt_q - 4'd1;
                     state_d     = S_INV_SHIFT;
                   end
      S_INV_SHIFT: if (bus.i_inv_shift_rows) state_d = S_INV_SUB;
      S_INV_SUB:   if (bus.i_inv_byte_subs) state_d = S_ADD;
      S_ADD:       if (bus.i_key_addition) begin
                     if (round_cnt_q != 4'd0) begin
                       state_d = S_INV_MIX;
                     end else begin
                       plain_d = bus.data;
                       state_d = S_SEND;
                     end
                   end
      S_INV_MIX:   if (bus.i_inv_mix_columns) state_d = S_INV_KEY;
      S_SEND:      if (bus.i_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
`ifdef AES_DEC_TIMEOUT_EN
    // an ack arriving in the timeout cycle still wins; every accepted ack changes state or round_cnt
    if (timeout && (state_d == state_q) && (round_cnt_d == round_cnt_q)) state_d = S_IDLE;
`endif
  end

  // Moore request decode from the next state so requests are registered and state-aligned
  always_comb begin
    req_d = 8'd0;
    case (state_d)
      S_LOAD_TXT, S_LOAD_KEY: req_d[R_LOAD]  = 1'b1;
      S_KEXP:                 req_d[R_KEXP]  = 1'b1;
      S_INV_KEY:              req_d[R_IKEY]  = 1'b1;
      S_INIT_ADD, S_ADD:      req_d[R_ADD]   = 1'b1;
      S_INV_SHIFT:            req_d[R_SHIFT] = 1'b1;
      S_INV_SUB:              req_d[R_SUB]   = 1'b1;
      S_INV_MIX:              req_d[R_MIX]   = 1'b1;
      S_SEND:                 req_d[R_SEND]  = 1'b1;
      default:                req_d          = 8'd0;
    endcase
  end

  // state, round index, captured registers and request outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      round_cnt_q <= 4'd0;
      cipher_q    <= '0;
      key_q       <= '0;
      plain_q     <= '0;
      req_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      cipher_q    <= cipher_d;
      key_q       <= key_d;
      plain_q     <= plain_d;
      req_q       <= req_d;
    end
  end

`ifdef AES_DEC_TIMEOUT_EN
  // wait counter restarts on any progress (state change or accepted KEXP ack)
  always_comb begin
    wait_d = '0;
    if ((state_d == state_q) && (round_cnt_d == round_cnt_q) && in_req) wait_d = wait_q + 1'b1;
  end

  // wait counter and one-cycle error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      error_q <= timeout && (state_d == S_IDLE);
    end
  end

  assign bus.o_error = error_q;
`else
  assign bus.o_error = 1'b0;
`endif

  assign bus.o_load               = req_q[R_LOAD];
  assign bus.o_calc_round_key     = req_q[R_KEXP];
  assign bus.o_calc_inv_round_key = req_q[R_IKEY];
  assign bus.o_add                = req_q[R_ADD];
  assign bus.o_inv_shift_rows     = req_q[R_SHIFT];
  assign bus.o_inv_substitute     = req_q[R_SUB];
  assign bus.o_inv_mix_columns    = req_q[R_MIX];
  assign bus.o_send               = req_q[R_SEND];
  assign bus.round_cnt            = round_cnt_q;
  assign bus.cipher_text          = cipher_q;
  assign bus.prime_key            = key_q;
  assign bus.plain_text           = plain_q;

endmodule

// File: tb/tb_aes_decrypt_fsm.sv
// Self-checking bench for aes_decrypt_fsm: acts as host and datapath, acking
// requests after random delays and comparing each request against a sequence
// built from the round structure of AES-128 decryption.
`timescale 1ns/1ps
module tb_aes_decrypt_fsm;
  localparam int NR = 10;
  localparam logic [7:0] Q_LOAD = 8'h80, Q_KEXP = 8'h40, Q_IKEY = 8'h20, Q_ADD = 8'h10,
                         Q_SHIFT = 8'h08, Q_SUB = 8'h04, Q_MIX = 8'h02, Q_SEND = 8'h01;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [127:0] exp_key = '0;
  logic [127:0] exp_plain = '0;
  logic [7:0]   req;

  aes_decrypt_fsm_if bus();
  aes_decrypt_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  assign req = {bus.o_load, bus.o_calc_round_key, bus.o_calc_inv_round_key, bus.o_add,
                bus.o_inv_shift_rows, bus.o_inv_substitute, bus.o_inv_mix_columns, bus.o_send};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_acks();
    bus.start = 0; bus.i_data_received_text = 0; bus.i_data_received_key = 0;
    bus.i_inv_shift_rows = 0; bus.i_inv_byte_subs = 0; bus.i_key_addition = 0;
    bus.i_inv_mix_columns = 0; bus.i_round_key_get_ready = 0; bus.i_done = 0;
  endtask

  // 0 text, 1 key, 2 shift, 3 sub, 4 add, 5 mix, 6 round key, 7 done, 8 start
  task automatic set_ack(input int idx);
    case (idx)
      0: bus.i_data_received_text = 1;
      1: bus.i_data_received_key = 1;
      2: bus.i_inv_shift_rows = 1;
      3: bus.i_inv_byte_subs = 1;
      4: bus.i_key_addition = 1;
      5: bus.i_inv_mix_columns = 1;
      6: bus.i_round_key_get_ready = 1;
      7: bus.i_done = 1;
      default: bus.start = 1;
    endcase
  endtask

  function automatic int match_idx(input logic [7:0] r, input int step);
    case (r)
      Q_LOAD:         return (step == 0) ? 0 : 1;
      Q_SHIFT:        return 2;
      Q_SUB:          return 3;
      Q_ADD:          return 4;
      Q_MIX:          return 5;
      default:        return 6;
    endcase
  endfunction

  task automatic pulse(input int idx);
    set_ack(idx);
    @(negedge clk);
    clear_acks();
  endtask

  task automatic run_once(input logic [127:0] txt, input logic [127:0] key, input logic [127:0] pt,
                          input bit both_in_txt, input bit stall_sub);
    logic [7:0] eq[$];
    int erc[$];
    int m, w, idx;
    bit stalled;
    stalled = 0;
    eq.push_back(Q_LOAD); erc.push_back(0);
    eq.push_back(Q_LOAD); erc.push_back(0);
    for (int k = 0; k < NR; k++) begin eq.push_back(Q_KEXP); erc.push_back(k); end
    eq.push_back(Q_ADD); erc.push_back(NR);
    for (int r = NR - 1; r >= 0; r--) begin
      eq.push_back(Q_IKEY);  erc.push_back(r + 1);
      eq.push_back(Q_SHIFT); erc.push_back(r);
      eq.push_back(Q_SUB);   erc.push_back(r);
      eq.push_back(Q_ADD);   erc.push_back(r);
      if (r != 0) begin eq.push_back(Q_MIX); erc.push_back(r); end
    end

    chk("idle_before_start", 128'(req), 128'(0));
    pulse(8);
    for (int i = 0; i < eq.size(); i++) begin
      chk($sformatf("req_step%0d", i), 128'(req), 128'(eq[i]));
      chk($sformatf("rcnt_step%0d", i), 128'(bus.round_cnt), 128'(erc[i]));
      m = match_idx(eq[i], i);
      if (eq[i] == Q_SHIFT) begin
        set_ack(5); set_ack(4); @(negedge clk); clear_acks();
        chk($sformatf("shift_hold_step%0d", i), 128'(req), 128'(Q_SHIFT));
      end
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 8);
        if (idx == m) idx = (idx + 1) % 9;
        bus.data = rnd128();
        pulse(idx);
        chk($sformatf("ignored_ack%0d_step%0d", idx, i), 128'(req), 128'(eq[i]));
        chk($sformatf("ignored_rcnt_step%0d", i), 128'(bus.round_cnt), 128'(erc[i]));
      end
      if (stall_sub && !stalled && eq[i] == Q_SUB) begin
        stalled = 1;
`ifdef AES_DEC_TIMEOUT_EN
        begin
          int cnt;
          bit seen;
          cnt = 0; seen = 0;
          for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk); cnt++;
            if (bus.o_error) seen = 1;
          end
          chk("timeout_seen", 128'(seen), 128'(1));
          chk("timeout_window", 128'(cnt >= 250 && cnt <= 260), 128'(1));
          chk("timeout_idle", 128'(req), 128'(0));
          @(negedge clk);
          chk("error_pulse_width", 128'(bus.o_error), 128'(0));
          chk("timeout_cipher_kept", bus.cipher_text, txt);
          chk("timeout_key_kept", bus.prime_key, key);
          chk("timeout_plain_kept", bus.plain_text, exp_plain);
          return;
        end
`else
        repeat (300) @(negedge clk);
        chk("stall_waits", 128'(req), 128'(Q_SUB));
        chk("stall_no_error", 128'(bus.o_error), 128'(0));
`endif
      end
      w = $urandom_range(0, 3);
      repeat (w) @(negedge clk);
      if (i == 0) bus.data = txt;
      else if (i == 1) bus.data = key;
      else if (i == eq.size() - 1) bus.data = pt;
      else bus.data = rnd128();
      set_ack(m);
      if (i == 0 && both_in_txt) set_ack(1);
      @(negedge clk);
      clear_acks();
      bus.data = rnd128();
      if (i == 0) begin
        chk("cipher_loaded", bus.cipher_text, txt);
        chk("key_untouched", bus.prime_key, exp_key);
      end
      if (i == 1) begin
        exp_key = key;
        chk("key_loaded", bus.prime_key, key);
        chk("cipher_after_key", bus.cipher_text, txt);
      end
    end
    exp_plain = pt;
    chk("send_req", 128'(req), 128'(Q_SEND));
    chk("plain_text", bus.plain_text, pt);
    chk("send_no_error", 128'(bus.o_error), 128'(0));
    w = $urandom_range(1, 5);
    repeat (w) @(negedge clk);
    chk("send_held", 128'(req), 128'(Q_SEND));
    pulse(7);
    chk("idle_after_done", 128'(req), 128'(0));
    chk("plain_hold", bus.plain_text, pt);
  endtask

  initial begin
    clear_acks();
    bus.data = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 128'(req), 128'(0));
    chk("rst_err", 128'(bus.o_error), 128'(0));
    chk("rst_rcnt", 128'(bus.round_cnt), 128'(0));
    chk("rst_cipher", bus.cipher_text, 128'(0));
    chk("rst_key", bus.prime_key, 128'(0));
    chk("rst_plain", bus.plain_text, 128'(0));
    reset = 1;
    @(negedge clk);

    run_once(128'h29C3505F571420F6402299B31A02D73A, 128'h5468617473206D79204B756E67204675,
             128'h54776F204F6E65204E696E652054776F, 0, 0);

    // abort mid key expansion
    pulse(8);
    bus.data = 128'h0123456789ABCDEF0123456789ABCDEF; pulse(0);
    bus.data = 128'hFEDCBA9876543210FEDCBA9876543210; pulse(1);
    repeat (5) pulse(6);
    chk("kexp_rcnt5", 128'(bus.round_cnt), 128'(5));
    pulse(8);
    chk("kexp_start_ignored", 128'(req), 128'(Q_KEXP));
    chk("kexp_start_rcnt", 128'(bus.round_cnt), 128'(5));
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("async_rst_req", 128'(req), 128'(0));
    chk("async_rst_rcnt", 128'(bus.round_cnt), 128'(0));
    chk("async_rst_cipher", bus.cipher_text, 128'(0));
    chk("async_rst_key", bus.prime_key, 128'(0));
    chk("async_rst_plain", bus.plain_text, 128'(0));
    exp_key = '0;
    exp_plain = '0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    run_once(rnd128(), rnd128(), rnd128(), 1, 0);
    for (int r = 0; r < 4; r++) run_once(rnd128(), rnd128(), rnd128(), $urandom_range(0, 1), 0);
    run_once(rnd128(), rnd128(), rnd128(), 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
